// File: rtl/datamem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : datamem_arbiter
// Purpose  : Shares the data-memory port between the CPU and the export port.
//            The CPU has priority, and a starvation counter forces an export grant.
// Revision : 1.0 - initial release
// ============================================================================
module datamem_arbiter #(
    parameter int DATA_W   = 16,
    parameter int DATA_A   = 11,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [DATA_A-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_stall,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              exp_req,
    input  logic              exp_we,
    input  logic [DATA_A-1:0] exp_addr,
    input  logic [DATA_W-1:0] exp_wdata,
    output logic              exp_gnt,
    output logic              exp_rvalid,
    output logic [DATA_W-1:0] exp_rdata,
    output logic [DATA_A-1:0] mem_address,
    output logic [DATA_W-1:0] mem_data,
    output logic              mem_MR,
    output logic              mem_MW,
    input  logic [DATA_W-1:0] mem_out
);

    // Read-return tag: records which requester owns the data arriving next cycle
    typedef logic [1:0] tag_t;
    localparam tag_t       c_TAG_NONE = 2'd0;
    localparam tag_t       c_TAG_CPU  = 2'd1;
    localparam tag_t       c_TAG_EXP  = 2'd2;
    localparam logic [3:0] c_MAX_WAIT = 4'(MAX_WAIT);

    tag_t       r_rd_tag;
    tag_t       w_rd_tag_next;
    logic [3:0] r_wait_cnt;
    logic [3:0] w_wait_next;
    logic       r_forced;
    logic       w_forced_next;
    logic       w_cpu_grant;
    logic       w_exp_grant;
    logic       w_grant_we;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_tag   <= c_TAG_NONE;
            r_wait_cnt <= '0;
            r_forced   <= 1'b0;
        end else begin
            r_rd_tag   <= w_rd_tag_next;
            r_wait_cnt <= w_wait_next;
            r_forced   <= w_forced_next;
        end
    end

    always_comb begin
        // A forced slot only blocks the CPU while the export is still asking
        w_cpu_grant = cpu_req & ~(r_forced & exp_req);
        w_exp_grant = exp_req & ~w_cpu_grant;
        cpu_stall   = cpu_req & ~w_cpu_grant;
        exp_gnt     = w_exp_grant;

        mem_address = '0;
        mem_data    = '0;
        w_grant_we  = 1'b0;
        if (w_cpu_grant) begin
            mem_address = cpu_addr;
            mem_data    = cpu_wdata;
            w_grant_we  = cpu_we;
        end else if (w_exp_grant) begin
            mem_address = exp_addr;
            mem_data    = exp_wdata;
            w_grant_we  = exp_we;
        end
        mem_MR = (w_cpu_grant | w_exp_grant) & ~w_grant_we;
        mem_MW = (w_cpu_grant | w_exp_grant) & w_grant_we;

        w_rd_tag_next = c_TAG_NONE;
        if (w_cpu_grant & ~cpu_we) begin
            w_rd_tag_next = c_TAG_CPU;
        end else if (w_exp_grant & ~exp_we) begin
            w_rd_tag_next = c_TAG_EXP;
        end

        w_wait_next = '0;
        if (exp_req & ~w_exp_grant) begin
            w_wait_next = (r_wait_cnt >= c_MAX_WAIT) ? c_MAX_WAIT : r_wait_cnt + 4'd1;
        end
        w_forced_next = (w_wait_next == c_MAX_WAIT);

        cpu_rvalid = (r_rd_tag == c_TAG_CPU);
        exp_rvalid = (r_rd_tag == c_TAG_EXP);
        cpu_rdata  = cpu_rvalid ? mem_out : '0;
        exp_rdata  = exp_rvalid ? mem_out : '0;
    end

endmodule
`default_nettype wire

// File: tb/tb_datamem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_datamem_arbiter
// Purpose  : Scoreboard bench for datamem_arbiter with a behavioural memory
//            model, directed scenarios and constrained-random traffic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_datamem_arbiter;

    localparam int DATA_W   = 16;
    localparam int DATA_A   = 11;
    localparam int MAX_WAIT = 4;
    localparam int DEPTH    = 1 << DATA_A;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              cpu_req = 1'b0;
    logic              cpu_we = 1'b0;
    logic [DATA_A-1:0] cpu_addr = '0;
    logic [DATA_W-1:0] cpu_wdata = '0;
    logic              cpu_stall;
    logic              cpu_rvalid;
    logic [DATA_W-1:0] cpu_rdata;
    logic              exp_req = 1'b0;
    logic              exp_we = 1'b0;
    logic [DATA_A-1:0] exp_addr = '0;
    logic [DATA_W-1:0] exp_wdata = '0;
    logic              exp_gnt;
    logic              exp_rvalid;
    logic [DATA_W-1:0] exp_rdata;
    logic [DATA_A-1:0] mem_address;
    logic [DATA_W-1:0] mem_data;
    logic              mem_MR;
    logic              mem_MW;
    logic [DATA_W-1:0] mem_out = '0;

    always #5 clk = ~clk;

    datamem_arbiter #(
        .DATA_W   (DATA_W),
        .DATA_A   (DATA_A),
        .MAX_WAIT (MAX_WAIT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .cpu_req     (cpu_req),
        .cpu_we      (cpu_we),
        .cpu_addr    (cpu_addr),
        .cpu_wdata   (cpu_wdata),
        .cpu_stall   (cpu_stall),
        .cpu_rvalid  (cpu_rvalid),
        .cpu_rdata   (cpu_rdata),
        .exp_req     (exp_req),
        .exp_we      (exp_we),
        .exp_addr    (exp_addr),
        .exp_wdata   (exp_wdata),
        .exp_gnt     (exp_gnt),
        .exp_rvalid  (exp_rvalid),
        .exp_rdata   (exp_rdata),
        .mem_address (mem_address),
        .mem_data    (mem_data),
        .mem_MR      (mem_MR),
        .mem_MW      (mem_MW),
        .mem_out     (mem_out)
    );

    // Memory device: write in the strobe cycle, read data one cycle after MR
    logic [DATA_W-1:0] dev_mem [DEPTH] = '{default: '0};
    always @(posedge clk) begin
        if (mem_MW) dev_mem[mem_address] <= mem_data;
        if (mem_MR) mem_out <= dev_mem[mem_address];
    end

    // Reference model state
    logic [DATA_W-1:0] ref_mem [DEPTH] = '{default: '0};
    int                m_wait = 0;
    logic [DATA_W-1:0] q_cpu [$];
    logic [DATA_W-1:0] q_exp [$];
    int                checks = 0;
    int                errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h at %0t", name, act, req, $time);
        end
    endtask

    // Drive one cycle, check the combinational response against the model
    task automatic step(input logic rst,
                        input logic c_req, input logic c_we,
                        input logic [DATA_A-1:0] c_addr, input logic [DATA_W-1:0] c_wd,
                        input logic e_req, input logic e_we,
                        input logic [DATA_A-1:0] e_addr, input logic [DATA_W-1:0] e_wd,
                        output logic c_g, output logic e_g);
        logic              starved;
        logic [DATA_A-1:0] a;
        logic [DATA_W-1:0] d;
        logic              we;
        @(negedge clk);
        reset     = rst;
        cpu_req   = c_req;
        cpu_we    = c_we;
        cpu_addr  = c_addr;
        cpu_wdata = c_wd;
        exp_req   = e_req;
        exp_we    = e_we;
        exp_addr  = e_addr;
        exp_wdata = e_wd;
        #1;
        starved = (m_wait >= MAX_WAIT);
        c_g = c_req && !(starved && e_req);
        e_g = e_req && !c_g;
        a  = c_g ? c_addr : (e_g ? e_addr : '0);
        d  = c_g ? c_wd   : (e_g ? e_wd   : '0);
        we = c_g ? c_we   : (e_g ? e_we   : 1'b0);
        if (!rst) begin
            check("cpu_stall",   cpu_stall,   c_req && !c_g);
            check("exp_gnt",     exp_gnt,     e_g);
            check("mem_MR",      mem_MR,      (c_g || e_g) && !we);
            check("mem_MW",      mem_MW,      (c_g || e_g) && we);
            check("mem_address", mem_address, a);
            check("mem_data",    mem_data,    d);
            if (c_g && !c_we) q_cpu.push_back(ref_mem[c_addr]);
            if (e_g && !e_we) q_exp.push_back(ref_mem[e_addr]);
        end
        if ((c_g || e_g) && we) ref_mem[a] = d;
        if (rst || !e_req || e_g) m_wait = 0;
        else if (m_wait < MAX_WAIT) m_wait++;
    endtask

    // Monitor: every cycle, each requester's return slot must match its queue
    initial begin
        logic [DATA_W-1:0] d;
        forever begin
            @(posedge clk);
            #2;
            if (q_cpu.size() > 0) begin
                d = q_cpu.pop_front();
                check("cpu_rvalid", cpu_rvalid, 1);
                check("cpu_rdata",  cpu_rdata,  d);
            end else begin
                check("cpu_rvalid_idle", cpu_rvalid, 0);
                check("cpu_rdata_idle",  cpu_rdata,  0);
            end
            if (q_exp.size() > 0) begin
                d = q_exp.pop_front();
                check("exp_rvalid", exp_rvalid, 1);
                check("exp_rdata",  exp_rdata,  d);
            end else begin
                check("exp_rvalid_idle", exp_rvalid, 0);
                check("exp_rdata_idle",  exp_rdata,  0);
            end
        end
    end

    initial begin
        logic              cg, eg;
        logic              cp, cw, ep, ew;
        logic [DATA_A-1:0] ca, ea;
        logic [DATA_W-1:0] cd, ed;
        int                first;
        logic              regain;

        // Reset held with a CPU read pending, then released
        step(1, 1, 0, 11'h005, 0, 0, 0, 0, 0, cg, eg);
        step(1, 1, 0, 11'h005, 0, 0, 0, 0, 0, cg, eg);
        step(0, 1, 0, 11'h005, 0, 0, 0, 0, 0, cg, eg);
        check("first_read_granted", cg, 1);

        // Write then read of the same address
        step(0, 1, 1, 11'h010, 16'h1234, 0, 0, 0, 0, cg, eg);
        step(0, 1, 0, 11'h010, 0, 0, 0, 0, 0, cg, eg);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, cg, eg);

        // Export-only read at the top address
        step(0, 0, 0, 0, 0, 1, 0, 11'h7FF, 0, cg, eg);
        check("exp_only_grant", eg, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, cg, eg);

        // Continuous contention: export forced through after MAX_WAIT denials
        first  = 0;
        regain = 1'b0;
        for (int i = 1; i <= MAX_WAIT + 2; i++) begin
            step(0, 1, 0, 11'(i), 0, 1, 0, 11'h100, 0, cg, eg);
            if (eg && first == 0) first = i;
            if (i == MAX_WAIT + 2) regain = cg;
        end
        check("starve_grant_cycle", first, MAX_WAIT + 1);
        check("cpu_regain", regain, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, cg, eg);

        // Simultaneous reads: CPU first, export once CPU releases
        step(0, 1, 0, 11'h001, 0, 1, 0, 11'h002, 0, cg, eg);
        check("simul_cpu_wins", {cg, eg}, 2'b10);
        step(0, 0, 0, 0, 0, 1, 0, 11'h002, 0, cg, eg);
        check("simul_exp_next", eg, 1);

        // Build up starvation, then reset with reads in flight
        step(0, 1, 0, 11'h003, 0, 1, 0, 11'h004, 0, cg, eg);
        step(0, 1, 0, 11'h003, 0, 1, 0, 11'h004, 0, cg, eg);
        step(0, 1, 0, 11'h003, 0, 1, 0, 11'h004, 0, cg, eg);
        step(1, 0, 0, 0, 0, 1, 0, 11'h004, 0, cg, eg);
        for (int i = 0; i < MAX_WAIT; i++) begin
            step(0, 1, 0, 11'h003, 0, 1, 0, 11'h004, 0, cg, eg);
            check("post_reset_cpu_wins", cg, 1);
        end
        step(0, 0, 0, 0, 0, 1, 0, 11'h004, 0, cg, eg);

        // Constrained-random traffic on a small address window for aliasing
        cp = 0; ep = 0; cw = 0; ew = 0; ca = '0; ea = '0; cd = '0; ed = '0;
        for (int n = 0; n < 2000; n++) begin
            if (!cp && $urandom_range(0, 99) < 60) begin
                cp = 1;
                cw = 1'($urandom_range(0, 1));
                ca = DATA_A'($urandom_range(0, 15));
                cd = DATA_W'($urandom);
            end
            if (!ep && $urandom_range(0, 99) < 50) begin
                ep = 1;
                ew = 1'($urandom_range(0, 1));
                ea = DATA_A'($urandom_range(0, 15));
                ed = DATA_W'($urandom);
            end
            step(($urandom_range(0, 299) == 0), cp, cw, ca, cd, ep, ew, ea, ed, cg, eg);
            if (cg) cp = 0;
            if (eg) ep = 0;
        end

        step(0, 0, 0, 0, 0, 0, 0, 0, 0, cg, eg);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, cg, eg);
        check("cpu_queue_drained", q_cpu.size(), 0);
        check("exp_queue_drained", q_exp.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
